ipd_scheduler: RTL and testbench

Sequencer for the servo I-PD control loop. Generates the fixed sample period, fetches the plant output yk from the ADC interface, and strobes the integral, derivative and total-action stages in order. It then saturates the resulting action and hands it to the PWM stage over a valid/ready handshake. It sits between the ADC front end, the I-PD datapath and the PWM generator.

---
 rtl/ipd_pkg.sv | 30 +++
 rtl/ipd_scheduler_if.sv | 27 ++
 rtl/ipd_sample_timer.sv | 33 +++
 rtl/ipd_scheduler.sv | 124 ++++++++++++
 tb/tb_ipd_scheduler.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ipd_pkg.sv
// Shared types, widths and the action saturation helper for the I-PD sequencer.
package ipd_pkg;

  localparam int YK_W      = 9;
  localparam int ACC_W     = 19;
  localparam int U_LIM_DEF = 32767;

  typedef logic signed [YK_W-1:0]  yk_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [2:0] {
    IDLE,
    ADC_REQ,
    INTEG,
    DERIV,
    COMP,
    SAT,
    OUT
  } state_t;

  // Both sides are full-width signed, so the compare never wraps.
  function automatic acc_t sat_acc(input acc_t a, input acc_t lim);
    if (a > lim)
      return lim;
    if (a < -lim)
      return -lim;
    return a;
  endfunction

endpackage

// File: rtl/ipd_scheduler_if.sv
// ADC, datapath and PWM handshake bundle; master is the scheduler side.
interface ipd_scheduler_if;
  import ipd_pkg::*;

  logic adc_req;
  logic adc_ack;
  yk_t  adc_data;
  yk_t  yk;
  logic integ_en;
  logic deriv_en;
  logic compute;
  acc_t acc;
  acc_t u;
  logic u_valid;
  logic u_ready;

  modport master (
    output adc_req, yk, integ_en, deriv_en, compute, u, u_valid,
    input  adc_ack, adc_data, acc, u_ready
  );

  modport slave (
    input  adc_req, yk, integ_en, deriv_en, compute, u, u_valid,
    output adc_ack, adc_data, acc, u_ready
  );

endinterface

// File: rtl/ipd_sample_timer.sv
// Free-running sample divider: one-cycle tick every SAMPLE_DIV clocks while enabled.
// Dropping enable parks the count at 0, so the next tick is a full period later.
module ipd_sample_timer #(
  parameter int SAMPLE_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] count;

  // A full sequence needs 7 cycles; shorter periods would overrun every sample.
  if (SAMPLE_DIV < 16) begin : g_bad_div
    $error("ipd_sample_timer: SAMPLE_DIV must be at least 16");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (!enable || count == LAST)
      count <= '0;
    else
      count <= count + 1'b1;
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/ipd_scheduler.sv
// I-PD loop sequencer: ADC fetch, integ/deriv/compute strobes, saturation, PWM handoff.
// Clamp to +/-U_LIM only when IPD_SCHED_SAT_EN is defined; otherwise acc passes through.
module ipd_scheduler
  import ipd_pkg::*;
#(
  parameter int SAMPLE_DIV  = 50000,
  parameter int ADC_TIMEOUT = 255,
  parameter int U_LIM       = U_LIM_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            clr_err,
  ipd_scheduler_if.master bus,
  output logic            busy,
  output logic            overrun,
  output logic            adc_err
);

  localparam int TW = $clog2(ADC_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(ADC_TIMEOUT - 1);

  if (U_LIM < 0 || U_LIM > 2**(ACC_W-1) - 1) begin : g_bad_ulim
    $error("ipd_scheduler: U_LIM does not fit the signed action width");
  end

  state_t        state, state_n;
  logic          tick;
  logic          timeout;
  logic [TW-1:0] tcnt;
  yk_t           yk_q;
  acc_t          u_q;
  acc_t          u_next;

  ipd_sample_timer #(.SAMPLE_DIV(SAMPLE_DIV)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n      = state;
    timeout      = 1'b0;
    bus.adc_req  = 1'b0;
    bus.integ_en = 1'b0;
    bus.deriv_en = 1'b0;
    bus.compute  = 1'b0;
    bus.u_valid  = 1'b0;
    case (state)
      IDLE:    if (tick) state_n = ADC_REQ;
      ADC_REQ: begin
        bus.adc_req = 1'b1;
        if (bus.adc_ack)
          state_n = INTEG;
        else if (tcnt == TLAST) begin
          timeout = 1'b1;
          state_n = IDLE;
        end
      end
      INTEG: begin bus.integ_en = 1'b1; state_n = DERIV; end
      DERIV: begin bus.deriv_en = 1'b1; state_n = COMP;  end
      COMP:  begin bus.compute  = 1'b1; state_n = SAT;   end
      SAT:   state_n = OUT;
      OUT: begin
        bus.u_valid = 1'b1;
        if (bus.u_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef IPD_SCHED_SAT_EN
  assign u_next = sat_acc(bus.acc, acc_t'(U_LIM));
`else
  assign u_next = bus.acc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
      yk_q <= '0;
      u_q  <= '0;
    end else begin
      if (state != ADC_REQ)
        tcnt <= '0;
      else
        tcnt <= tcnt + 1'b1;
      if (state == ADC_REQ && bus.adc_ack)
        yk_q <= bus.adc_data;
      if (state == SAT)
        u_q <= u_next;
    end
  end

  // Set is evaluated after clear so a same-cycle event wins over clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
      adc_err <= 1'b0;
    end else begin
      if (clr_err) begin
        overrun <= 1'b0;
        adc_err <= 1'b0;
      end
      if (tick && state != IDLE)
        overrun <= 1'b1;
      if (timeout)
        adc_err <= 1'b1;
    end
  end

  assign bus.yk = yk_q;
  assign bus.u  = u_q;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_ipd_scheduler.sv
// Directed bench for ipd_scheduler with a queue-based output scoreboard.
module tb_ipd_scheduler;
  import ipd_pkg::*;

  localparam int DIV = 16;
  localparam int TO  = 8;
  localparam int LIM = 32767;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic clr_err = 1'b0;
  logic busy, overrun, adc_err;

  ipd_scheduler_if bus();

  ipd_scheduler #(.SAMPLE_DIV(DIV), .ADC_TIMEOUT(TO), .U_LIM(LIM)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .clr_err (clr_err),
    .bus     (bus),
    .busy    (busy),
    .overrun (overrun),
    .adc_err (adc_err)
  );

  always #5 clk = ~clk;

  int asserts  = 0;
  int fails    = 0;
  int n_out    = 0;
  int n_exp    = 0;
  int n_strobe = 0;
  int exp_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Load acc and queue the u the PWM side must receive for it.
  task automatic push(input int a, input int exp_sat, input int exp_raw);
    bus.acc = acc_t'(a);
`ifdef IPD_SCHED_SAT_EN
    exp_q.push_back(exp_sat);
`else
    exp_q.push_back(exp_raw);
`endif
    n_exp++;
  endtask

  function automatic logic sig(input int s);
    case (s)
      0: return bus.adc_req;
      1: return bus.integ_en;
      2: return bus.deriv_en;
      3: return bus.compute;
      4: return bus.u_valid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_high(input string nm, input int s, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig(s) && n < budget);
    if (!sig(s)) begin
      asserts++;
      fails++;
      $display("FAIL %s: wait expired after %0d cycles", nm, n);
    end
  endtask

  task automatic wait_outs(input string nm);
    for (int i = 0; i < 200 && n_out < n_exp; i++)
      @(negedge clk);
    chk(nm, n_out, n_exp);
  endtask

  // Monitor: strobe ordering and scoreboard pops on each PWM handshake.
  logic p_ack, p_int, p_der, p_comp, p2_comp, p_uv;
  always @(negedge clk) begin
    if (rst) begin
      p_ack = 0; p_int = 0; p_der = 0; p_comp = 0; p2_comp = 0; p_uv = 0;
    end else begin
      if (bus.integ_en) chk("integ_after_ack", int'(p_ack), 1);
      if (bus.deriv_en) chk("deriv_after_integ", int'(p_int), 1);
      if (bus.compute)  chk("compute_after_deriv", int'(p_der), 1);
      if (bus.integ_en || bus.deriv_en || bus.compute) begin
        chk("strobe_onehot", int'($onehot({bus.integ_en, bus.deriv_en, bus.compute})), 1);
        n_strobe++;
      end
      if (bus.u_valid && !p_uv) chk("uvalid_two_after_compute", int'(p2_comp), 1);
      if (bus.u_valid && bus.u_ready) begin
        if (exp_q.size() == 0) begin
          asserts++;
          fails++;
          $display("FAIL u_out: unexpected output %0d, expected none", $signed(bus.u));
        end else begin
          chk("u_out", int'($signed(bus.u)), exp_q.pop_front());
        end
        n_out++;
      end
      p_ack   = bus.adc_req && bus.adc_ack;
      p_int   = bus.integ_en;
      p_der   = bus.deriv_en;
      p2_comp = p_comp;
      p_comp  = bus.compute;
      p_uv    = bus.u_valid;
    end
  end

  initial begin
    int n, len, s0, reqs;
    logic stable;

    bus.adc_ack  = 1'b1;
    bus.adc_data = yk_t'(10);
    bus.acc      = '0;
    bus.u_ready  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_strobes", int'({bus.adc_req, bus.integ_en, bus.deriv_en, bus.compute, bus.u_valid}), 0);
    chk("rst_flags", int'({busy, overrun, adc_err}), 0);
    chk("rst_u", int'($signed(bus.u)), 0);
    chk("rst_yk", int'($signed(bus.yk)), 0);

    // Nominal loop, three samples of acc=500
    enable = 1'b1;
    push(500, 500, 500);
    push(500, 500, 500);
    push(500, 500, 500);
    rst = 1'b0;
    wait_high("first_req", 0, 40, n);
    chk("first_req_cycles", n, 16);
    wait_high("second_req", 0, 40, n);
    chk("sample_period", n, 16);
    wait_outs("nominal_outs");
    chk("yk_latched", int'($signed(bus.yk)), 10);

    // Saturation boundaries
    push(100000, 32767, 100000);   wait_outs("sat_pos");
    push(-100000, -32767, -100000); wait_outs("sat_neg");
    push(32767, 32767, 32767);     wait_outs("sat_edge_pos");
    push(-32768, -32767, -32768);  wait_outs("sat_edge_neg");

    // ADC timeout
    bus.adc_ack  = 1'b0;
    bus.adc_data = yk_t'(55);
    wait_high("timeout_req", 0, 40, n);
    enable = 1'b0;
    s0 = n_strobe;
    len = 0;
    while (bus.adc_req && len < 50) begin
      len++;
      @(negedge clk);
    end
    chk("timeout_req_len", len, TO);
    chk("adc_err_set", int'(adc_err), 1);
    chk("timeout_idle", int'(busy), 0);
    chk("timeout_no_strobes", n_strobe, s0);
    chk("yk_held", int'($signed(bus.yk)), 10);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("adc_err_clr", int'(adc_err), 0);

    // PWM stall: overrun while holding u
    bus.adc_ack  = 1'b1;
    bus.adc_data = yk_t'(-3);
    bus.u_ready  = 1'b0;
    enable = 1'b1;
    push(1234, 1234, 1234);
    wait_high("stall_valid", 4, 40, n);
    stable = 1'b1;
    reqs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.u_valid || $signed(bus.u) != 1234) stable = 1'b0;
      if (bus.adc_req) reqs++;
    end
    chk("stall_u_stable", int'(stable), 1);
    chk("stall_no_req", reqs, 0);
    chk("overrun_set", int'(overrun), 1);
    chk("yk_signed", int'($signed(bus.yk)), -3);
    bus.u_ready = 1'b1;
    wait_outs("stall_release");
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("overrun_clr", int'(overrun), 0);

    // Reset in the middle of a sequence
    bus.acc = acc_t'(777);
    wait_high("rst_deriv", 2, 40, n);
    rst = 1'b1;
    #1;
    chk("midrst_strobes", int'({bus.adc_req, bus.integ_en, bus.deriv_en, bus.compute, bus.u_valid}), 0);
    chk("midrst_state", int'({busy, overrun, adc_err}), 0);
    chk("midrst_u_yk", int'($signed(bus.u)) + int'($signed(bus.yk)), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push(777, 777, 777);
    wait_high("post_rst_integ", 1, 60, n);
    chk("post_rst_first_strobe", n, 17);
    wait_outs("post_rst_out");

    // Enable dropped during compute
    push(-5, -5, -5);
    wait_high("drop_compute", 3, 40, n);
    enable = 1'b0;
    wait_outs("drop_finish");
    reqs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.adc_req) reqs++;
    end
    chk("drop_no_req", reqs, 0);
    chk("drop_idle", int'(busy), 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
